instr_fetch: RTL and testbench

- Next-PC and fetch front end. It produces the PC stream that the program counter register consumes, and issues word reads to instruction memory over a req/gnt/rvalid interface.
- Returned instructions are buffered in a 2-entry queue and handed to decode on a valid/ready handshake.
- Branch and jump redirects reload the PC, flush the queue and discard any in-flight response.

---
 rtl/instr_fetch.sv | 119 +++++++++++
 tb/tb_instr_fetch.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch front end: sequential PC generation, single-outstanding imem reads,
// 2-entry {pc, instr} queue to decode, and redirect with stale-response discard.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDrop} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [1:0]  count_q, count_d, count_post;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        push, pop;
    logic [31:0] fifo_pc_q    [2];
    logic [31:0] fifo_instr_q [2];

    // Redirect targets are word aligned; the low bits carry no information.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
        pop        = (count_q != 2'd0) && if_ready;
        count_post = count_q + 2'd1 - {1'b0, pop};

        unique case (state_q)
            StIdle: if (count_q < 2'd2) state_d = StReq;
            StReq: begin
                if (imem_gnt) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'(PC_STEP);
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = (count_post < 2'd2) ? StReq : StIdle;
                end
            end
            StDrop: if (imem_rvalid) state_d = StReq;
        endcase

        // A request granted on the old path must have its response drained in StDrop.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            push       = 1'b0;
            pop        = 1'b0;
            unique case (state_q)
                StIdle: state_d = StReq;
                StReq:  state_d = imem_gnt ? StDrop : StReq;
                StWait: state_d = imem_rvalid ? StReq : StDrop;
                StDrop: state_d = imem_rvalid ? StReq : StDrop;
            endcase
        end

        if (redirect_valid) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
            rd_ptr_d = rd_ptr_q ^ pop;
            wr_ptr_d = wr_ptr_q ^ push;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 32'h0;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= req_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assign imem_req  = (state_q == StReq);
    assign imem_addr = fetch_pc_q;
    assign if_valid  = (count_q != 2'd0);
    assign if_pc     = if_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
    assign if_instr  = if_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a latency-configurable memory responder plus a stream model that
// expects decode to see consecutive word PCs from the last redirect target onwards.
module tb_instr_fetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    // Memory responder state
    bit          pend_valid = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          pend_cnt = 0;
    int          gnt_hold = 0;
    int          gnt_max = 0;
    int          rsp_min = 1;
    int          rsp_max = 1;

    // Stream model state
    logic [31:0] exp_pc = 32'h0;
    int          pops = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    instr_fetch #(
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .if_ready      (if_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // One clock cycle: drive memory at negedge, check handshakes, update memory after posedge.
    task automatic tick();
        logic [31:0] addr_now;
        @(negedge clk);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (pend_valid && pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr ^ KEY;
        end
        if (imem_req && gnt_hold == 0) imem_gnt = 1'b1;
        addr_now = imem_addr;

        if (imem_req) begin
            tests_run++;
            if (pend_valid) begin
                tests_failed++;
                $display("FAIL outstanding: req=%0b while response pending, required no request",
                         imem_req);
            end
        end
        if (prev_stall) begin
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
                tests_failed++;
                $display("FAIL addr_hold: req=%0b addr=%h, required req=1 addr=%h",
                         imem_req, imem_addr, prev_addr);
            end
        end
        if (if_valid && if_ready && !redirect_valid) begin
            tests_run++;
            if (if_pc !== exp_pc || if_instr !== (exp_pc ^ KEY)) begin
                tests_failed++;
                $display("FAIL stream: pc=%h instr=%h, required pc=%h instr=%h",
                         if_pc, if_instr, exp_pc, exp_pc ^ KEY);
            end
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (redirect_valid) exp_pc = redirect_pc & ~32'd3;
        prev_stall = reset && imem_req && !imem_gnt && !redirect_valid;
        prev_addr  = addr_now;

        @(posedge clk);
        if (imem_rvalid) pend_valid = 1'b0;
        else if (pend_valid) pend_cnt--;
        if (imem_gnt) begin
            pend_valid = 1'b1;
            pend_addr  = addr_now;
            pend_cnt   = $urandom_range(rsp_max, rsp_min) - 1;
            gnt_hold   = $urandom_range(gnt_max, 0);
        end else if (imem_req && gnt_hold > 0) begin
            gnt_hold--;
        end
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        pend_valid     = 1'b0;
        gnt_hold       = 0;
        gnt_max        = 0;
        rsp_min        = 1;
        rsp_max        = 1;
        exp_pc         = 32'h0;
        prev_stall     = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_req_addr(input logic [31:0] addr, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == addr) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL %s: no request to %h within 40 cycles, last addr=%h", name, addr,
                     imem_addr);
        end
    endtask

    task automatic wait_pops(input int n, input string name);
        int start = pops;
        for (int i = 0; i < 60 && pops < start + n; i++) tick();
        tests_run++;
        if (pops < start + n) begin
            tests_failed++;
            $display("FAIL %s: %0d instructions delivered, required %0d", name, pops - start, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        tests_run++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_imem: req=%0b addr=%h, required req=0 addr=0", imem_req,
                     imem_addr);
        end
        tests_run++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_if: valid=%0b pc=%h instr=%h, required 0/0/0", if_valid, if_pc,
                     if_instr);
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL first_req: req=%0b addr=%h, required req=1 addr=0", imem_req,
                     imem_addr);
        end
    endtask

    task automatic test_sequential();
        if_ready = 1'b1;
        wait_pops(4, "seq_stream");
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (8) tick();
        tests_run++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h8) begin
            tests_failed++;
            $display("FAIL full_idle: req=%0b addr=%h, required req=0 addr=8", imem_req,
                     imem_addr);
        end
        tests_run++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== KEY) begin
            tests_failed++;
            $display("FAIL full_head: valid=%0b pc=%h instr=%h, required 1/0/%h", if_valid,
                     if_pc, if_instr, KEY);
        end
        if_ready = 1'b1;
        wait_req_addr(32'h8, "resume_req");
        wait_pops(2, "resume_stream");
    endtask

    task automatic test_gnt_stall();
        do_reset();
        if_ready = 1'b1;
        wait_req_addr(32'h4, "stall_setup");
        gnt_hold = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
                tests_failed++;
                $display("FAIL stall_hold: req=%0b addr=%h, required req=1 addr=4", imem_req,
                         imem_addr);
            end
        end
        tick();
        tests_run++;
        if (imem_req !== 1'b0 || imem_addr !== 32'h8) begin
            tests_failed++;
            $display("FAIL stall_release: req=%0b addr=%h, required req=0 addr=8", imem_req,
                     imem_addr);
        end
        wait_pops(2, "stall_stream");
    endtask

    task automatic test_redirect_wait();
        do_reset();
        rsp_min = 3;
        rsp_max = 3;
        repeat (14) tick();
        if_ready = 1'b1;
        tick();
        if_ready = 1'b0;
        wait_req_addr(32'h8, "rw_setup");
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        redirect_valid = 1'b0;
        tests_run++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL rw_flush: valid=%0b req=%0b, required valid=0 req=0", if_valid,
                     imem_req);
        end
        tick();
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL rw_drop: req=%0b, required 0", imem_req);
        end
        tick();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rw_target: req=%0b addr=%h valid=%0b, required req=1 addr=100 valid=0",
                     imem_req, imem_addr, if_valid);
        end
        if_ready = 1'b1;
        wait_pops(2, "rw_stream");
    endtask

    task automatic test_redirect_gnt();
        do_reset();
        if_ready = 1'b1;
        wait_req_addr(32'h10, "rg_setup");
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        redirect_valid = 1'b0;
        tests_run++;
        if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL rg_drop: req=%0b, required 0", imem_req);
        end
        tick();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            tests_failed++;
            $display("FAIL rg_target: req=%0b addr=%h, required req=1 addr=200", imem_req,
                     imem_addr);
        end
        wait_req_addr(32'h208, "rn_setup");
        gnt_hold       = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_valid = 1'b0;
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            tests_failed++;
            $display("FAIL rn_target: req=%0b addr=%h, required req=1 addr=300", imem_req,
                     imem_addr);
        end
        wait_pops(2, "rn_stream");
    endtask

    task automatic test_wrap_and_reset();
        bit in_wait = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        wait_pops(2, "wrap_stream");
        rsp_min = 3;
        rsp_max = 3;
        for (int i = 0; i < 20; i++) begin
            if (pend_valid && !imem_req) begin
                in_wait = 1'b1;
                break;
            end
            tick();
        end
        tests_run++;
        if (!in_wait) begin
            tests_failed++;
            $display("FAIL mid_reset_setup: no outstanding request within 20 cycles");
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (if_valid !== 1'b0 || imem_addr !== 32'h0 || imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: valid=%0b addr=%h req=%0b, required 0/0/0", if_valid,
                     imem_addr, imem_req);
        end
        exp_pc     = 32'h0;
        prev_stall = 1'b0;
        tick();
        tick();
        reset      = 1'b1;
        rsp_min    = 1;
        rsp_max    = 1;
        pend_valid = 1'b1;
        pend_cnt   = 0;
        pend_addr  = 32'hDEAD_BEE0;
        tick();
        tests_run++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL late_rvalid: req=%0b addr=%h valid=%0b, required req=1 addr=0 valid=0",
                     imem_req, imem_addr, if_valid);
        end
        wait_pops(2, "post_reset_stream");
    endtask

    task automatic test_random();
        int start;
        do_reset();
        gnt_max = 2;
        rsp_min = 1;
        rsp_max = 3;
        start   = pops;
        for (int i = 0; i < 800; i++) begin
            if_ready       = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(19, 0) == 0);
            redirect_pc    = $urandom;
            tick();
            redirect_valid = 1'b0;
        end
        tests_run++;
        if (pops - start < 50) begin
            tests_failed++;
            $display("FAIL random_progress: %0d instructions delivered, required at least 50",
                     pops - start);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_gnt_stall();
        test_redirect_wait();
        test_redirect_gnt();
        test_wrap_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
